mmio_port_responder: RTL and testbench
======================================

Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus (MemWrite/MemRead/Address/WriteData in, ReadData out).
- Services the CPU's load/store accesses to a small register window.
- Turns stores into a buffered valid/ready output stream on PortOut.
- Presents a synchronized, change-flagged view of the 8-bit PortIn to loads.
- Sits beside DataMemory; the top level selects ReadData from this block when Hit=1.

Parameters:
- BASE_ADDR, 32'h1001_0040: byte address of the register window. 16-byte aligned.
- FIFO_DEPTH, 4: output FIFO entries. Power of two, at least 2.
- DATA_WIDTH, 32: width of the data bus and of FIFO entries.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- MemWrite  input  1  store strobe from the control path.
- MemRead  input  1  load strobe from the control path.
- Address  input  32  byte address (ALU result).
- WriteData  input  DATA_WIDTH  store data (register file read port 2).
- ReadData  output  DATA_WIDTH  load data. Combinational.
- Hit  output  1  Address falls in the window. Combinational.
- PortIn  input  8  asynchronous external input.
- PortOut  output  DATA_WIDTH  FIFO head data.
- PortOutValid  output  1  FIFO not empty.
- PortOutReady  input  1  consumer accepts the head entry.

Behaviour:
- Decode:
  - Hit = (Address[31:4] == BASE_ADDR[31:4]).
  - offset = Address[3:2]; Address[1:0] are ignored.
- Register map:
  - 0x0 TX_DATA. Write pushes into the FIFO. Read returns the last value accepted by a push.
  - 0x4 RX_DATA. Read-only; returns {24'b0, rx_sync}.
  - 0x8 STATUS. bit0 tx_empty, bit1 tx_full, bit2 tx_overflow (sticky), bit3 rx_changed (sticky), bits[8+:log2(FIFO_DEPTH)+1] tx_count, all other bits 0. Writing 1 to bit2 or bit3 clears that flag (W1C); other bits are read-only.
  - 0xC: reserved (see Optional Feature).
- Reads:
  - Fully combinational, zero cycles, to match the single-cycle datapath.
  - ReadData = 0 when MemRead=0 or Hit=0.
  - Reads have no side effects.
- Writes take effect on the rising clk edge with MemWrite && Hit.
- Push = TX_DATA write && (!full || pop in the same cycle).
- Pop = PortOutValid && PortOutReady.
- Push and pop in the same cycle: count unchanged, pointers both advance. This holds when full and also when count=1.
- TX_DATA write while full with no pop: data is dropped, tx_overflow is set, and the last-value register is not updated.
- PortOut = head entry when non-empty, 0 when empty.
- PortOutValid asserts the cycle after the first push into an empty FIFO.
- PortOut/PortOutValid are held stable while PortOutReady=0.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- PortIn passes through a 2-flop synchronizer to give rx_sync; rx_prev is rx_sync delayed one cycle.
- rx_changed is set when rx_sync != rx_prev.
- Latency:
  - PortIn edge to RX_DATA: 2 clk.
  - PortIn edge to rx_changed visible: 3 clk.
- Simultaneous set and W1C on a sticky flag: set wins.
- Reset (asynchronous, reset=0):
  - FIFO emptied, pointers and count = 0.
  - Last-value register, sync flops, rx_prev and sticky flags = 0.
  - PortOutValid = 0, PortOut = 0.
  - Reset mid-transfer discards all queued entries. No partial state survives.

Optional Feature:
- Macro: RX_EDGE_COUNT_EN.
- With the macro: offset 0xC is RX_EDGES, a 16-bit counter zero-extended to 32 bits.
  - Increments on each rising edge of rx_sync[0] (rx_sync[0] && !rx_prev[0]).
  - Wraps 0xFFFF to 0x0000.
  - Any write to 0xC clears it. Clear and increment in the same cycle gives 0.
  - Reset value 0.
- Without the macro: 0xC reads 0, writes are ignored, and no counter logic is built.

Decomposition:
- Package mmio_port_pkg holds:
  - Register offsets: OFF_TX_DATA, OFF_RX_DATA, OFF_STATUS, OFF_RX_EDGES.
  - STATUS bit positions: ST_TX_EMPTY, ST_TX_FULL, ST_TX_OVF, ST_RX_CHG, ST_COUNT_LSB.
  - Edge counter width.
- One sub-module, mmio_tx_fifo.
  - Parameterized synchronous FIFO with push/pop, data out, full, empty and count.
  - Implements the simultaneous push/pop rule.

Test Plan:
- Reset, then read 0x8 -> STATUS=32'h0000_0001, PortOutValid=0, PortOut=0.
- Store 0xDEAD_BEEF to BASE+0x0 with PortOutReady=0 -> next cycle PortOutValid=1, PortOut=0xDEAD_BEEF, STATUS count=1; raising Ready for one cycle pops -> Valid=0.
- Push 5 words with Ready=0, FIFO_DEPTH=4 -> fifth dropped; STATUS=0x0000_0406 (count 4, full, overflow); write 0x4 to 0x8 -> overflow clears; PortOut order is first four words.
- With FIFO full and Ready=1, store 0x55 -> pop and push in the same cycle, count stays 4, no overflow, 0x55 appears last.
- Drive PortIn 0x00->0xA5 -> RX_DATA=0x0000_00A5 after 2 clk, rx_changed=1 after 3 clk; W1C bit3 in the same cycle as a new change -> flag stays 1.
- Assert reset with 3 entries queued -> Valid=0, count=0 immediately without clk; with RX_EDGE_COUNT_EN, toggling PortIn[0] 3 times -> RX_EDGES=3.

Source files
------------

// File: rtl/mmio_port_pkg.sv
// mmio_port_pkg: shared constants for the MMIO port responder.
//   - register word offsets (Address[3:2])
//   - STATUS bit positions
//   - RX edge counter width (used only when RX_EDGE_COUNT_EN is defined)
package mmio_port_pkg;

    localparam logic [1:0] OFF_TX_DATA  = 2'd0;
    localparam logic [1:0] OFF_RX_DATA  = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_RX_EDGES = 2'd3;

    localparam int ST_TX_EMPTY  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_TX_OVF    = 2;
    localparam int ST_RX_CHG    = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int EDGE_CNT_W = 16;

endpackage

// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo: synchronous FIFO for the TX stream.
// Ports:
//   clk, reset     clock, async active-low reset
//   push, pop      enqueue / dequeue strobes; caller only pushes when not
//                  full (or popping) and only pops when not empty
//   wdata, rdata   entry in / head entry out (0 when empty)
//   full, empty    occupancy flags
//   count          entries held, 0..DEPTH
// A simultaneous push and pop advances both pointers and leaves count
// unchanged, including the full case where wptr == rptr.
module mmio_tx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the output is gated by empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: MMIO register window on the data-memory bus.
// Stores to TX_DATA feed a valid/ready output stream; loads see a
// synchronized, change-flagged view of PortIn.
// Ports:
//   clk, reset              clock, async active-low reset
//   MemWrite, MemRead       store / load strobes
//   Address, WriteData      byte address, store data
//   ReadData, Hit           combinational load data / window decode
//   PortIn                  async 8-bit input
//   PortOut, PortOutValid   FIFO head stream
//   PortOutReady            consumer accept
// Build option: define RX_EDGE_COUNT_EN to add the RX_EDGES counter at 0xC.
module mmio_port_responder
    import mmio_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0040,
    parameter int          FIFO_DEPTH = 4,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Hit,
    input  logic [7:0]            PortIn,
    output logic [DATA_WIDTH-1:0] PortOut,
    output logic                  PortOutValid,
    input  logic                  PortOutReady
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0] offset;
    logic       addr_unused;
    logic       wr, tx_wr, st_wr;
    logic       push, pop, full, empty;
    logic       ovf_set, chg_set;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] last_val;
    logic [DATA_WIDTH-1:0] status;
    logic [7:0] rx_meta, rx_sync, rx_prev;
    logic       tx_ovf, rx_chg;

    assign Hit         = (Address[31:4] == BASE_ADDR[31:4]);
    assign offset      = Address[3:2];
    assign addr_unused = ^Address[1:0];

    assign wr    = MemWrite && Hit;
    assign tx_wr = wr && (offset == OFF_TX_DATA);
    assign st_wr = wr && (offset == OFF_STATUS);

    // A full FIFO still accepts a store when the head leaves this cycle.
    assign pop     = !empty && PortOutReady;
    assign push    = tx_wr && (!full || pop);
    assign ovf_set = tx_wr && full && !pop;
    assign chg_set = (rx_sync != rx_prev);

    mmio_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (WriteData),
        .rdata (PortOut),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign PortOutValid = !empty;

    // Sticky flags: a set in the same cycle as a W1C wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_val <= '0;
            rx_meta  <= '0;
            rx_sync  <= '0;
            rx_prev  <= '0;
            tx_ovf   <= 1'b0;
            rx_chg   <= 1'b0;
        end else begin
            if (push) last_val <= WriteData;
            rx_meta <= PortIn;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (ovf_set)                            tx_ovf <= 1'b1;
            else if (st_wr && WriteData[ST_TX_OVF]) tx_ovf <= 1'b0;
            if (chg_set)                            rx_chg <= 1'b1;
            else if (st_wr && WriteData[ST_RX_CHG]) rx_chg <= 1'b0;
        end
    end

`ifdef RX_EDGE_COUNT_EN
    logic [EDGE_CNT_W-1:0] rx_edges;
    logic                  edge_clr;

    assign edge_clr = wr && (offset == OFF_RX_EDGES);

    // Clear beats a coincident increment; counter wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           rx_edges <= '0;
        else if (edge_clr)                    rx_edges <= '0;
        else if (rx_sync[0] && !rx_prev[0])   rx_edges <= rx_edges + 1'b1;
    end
`endif

    always_comb begin
        status                        = '0;
        status[ST_TX_EMPTY]           = empty;
        status[ST_TX_FULL]            = full;
        status[ST_TX_OVF]             = tx_ovf;
        status[ST_RX_CHG]             = rx_chg;
        status[ST_COUNT_LSB +: CW]    = count;
    end

    always_comb begin
        ReadData = '0;
        if (MemRead && Hit) begin
            case (offset)
                OFF_TX_DATA: ReadData = last_val;
                OFF_RX_DATA: ReadData = DATA_WIDTH'(rx_sync);
                OFF_STATUS:  ReadData = status;
`ifdef RX_EDGE_COUNT_EN
                OFF_RX_EDGES: ReadData = DATA_WIDTH'(rx_edges);
`endif
                default:     ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder with hand-computed expectations.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE = 32'h1001_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead;
    logic [31:0] Address, WriteData, ReadData, PortOut;
    logic        Hit, PortOutValid, PortOutReady;
    logic [7:0]  PortIn;

    int n_chk  = 0;
    int n_fail = 0;

    mmio_port_responder dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .Address      (Address),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .Hit          (Hit),
        .PortIn       (PortIn),
        .PortOut      (PortOut),
        .PortOutValid (PortOutValid),
        .PortOutReady (PortOutReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        Address   = BASE + off;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rchk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        Address = BASE + off;
        MemRead = 1'b1;
        #1;
        chk(tag, ReadData, exp);
        MemRead = 1'b0;
    endtask

    logic [31:0] words [5] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                               32'h4444_4444, 32'h9999_9999};
    logic [31:0] drain [4] = '{32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                               32'h0000_0055};

    initial begin
        reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        Address = '0; WriteData = '0; PortIn = '0; PortOutReady = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // reset state
        rchk("rst_status", 32'h8, 32'h0000_0001);
        chk("rst_valid", {31'b0, PortOutValid}, 32'd0);
        chk("rst_portout", PortOut, 32'd0);
        rchk("rst_txdata", 32'h0, 32'd0);

        // decode boundaries
        Address = BASE + 32'h10; MemRead = 1'b1; #1;
        chk("miss_hit", {31'b0, Hit}, 32'd0);
        chk("miss_rdata", ReadData, 32'd0);
        Address = BASE + 32'hA; MemRead = 1'b0; #1;
        chk("noread_rdata", ReadData, 32'd0);
        chk("lowbits_hit", {31'b0, Hit}, 32'd1);
        rchk("lowbits_status", 32'hA, 32'h0000_0001);
        tick();

        // single push / pop
        wr(32'h0, 32'hDEAD_BEEF);
        chk("push1_valid", {31'b0, PortOutValid}, 32'd1);
        chk("push1_portout", PortOut, 32'hDEAD_BEEF);
        rchk("push1_status", 32'h8, 32'h0000_0100);
        rchk("push1_txdata", 32'h0, 32'hDEAD_BEEF);
        PortOutReady = 1'b1;
        tick();
        PortOutReady = 1'b0;
        chk("pop1_valid", {31'b0, PortOutValid}, 32'd0);
        chk("pop1_portout", PortOut, 32'd0);

        // overflow
        for (int i = 0; i < 5; i++) wr(32'h0, words[i]);
        rchk("ovf_status", 32'h8, 32'h0000_0406);
        rchk("ovf_txdata", 32'h0, 32'h4444_4444);
        chk("ovf_head", PortOut, 32'h1111_1111);
        wr(32'h8, 32'h4);
        rchk("ovf_w1c", 32'h8, 32'h0000_0402);

        // push + pop while full
        PortOutReady = 1'b1;
        wr(32'h0, 32'h0000_0055);
        PortOutReady = 1'b0;
        rchk("fullpp_status", 32'h8, 32'h0000_0402);
        rchk("fullpp_txdata", 32'h0, 32'h0000_0055);
        PortOutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), PortOut, drain[i]);
            tick();
        end
        PortOutReady = 1'b0;
        chk("drain_valid", {31'b0, PortOutValid}, 32'd0);
        rchk("drain_status", 32'h8, 32'h0000_0001);

        // RX synchronizer and change flag
        PortIn = 8'hA5;
        tick();
        rchk("rx_1clk", 32'h4, 32'h0000_0000);
        tick();
        rchk("rx_2clk", 32'h4, 32'h0000_00A5);
        rchk("chg_2clk", 32'h8, 32'h0000_0001);
        tick();
        rchk("chg_3clk", 32'h8, 32'h0000_0009);
        wr(32'h8, 32'h8);
        rchk("chg_w1c", 32'h8, 32'h0000_0001);
        PortIn = 8'h5A;
        tick();
        tick();
        wr(32'h8, 32'h8);
        rchk("chg_setwins", 32'h8, 32'h0000_0009);
        wr(32'h8, 32'h8);
        rchk("chg_clr2", 32'h8, 32'h0000_0001);

`ifdef RX_EDGE_COUNT_EN
        wr(32'hC, 32'h0);
        rchk("edges_clr", 32'hC, 32'd0);
        for (int i = 0; i < 3; i++) begin
            PortIn[0] = 1'b1;
            repeat (3) tick();
            PortIn[0] = 1'b0;
            repeat (3) tick();
        end
        repeat (3) tick();
        rchk("edges_3", 32'hC, 32'd3);
`else
        wr(32'hC, 32'hFFFF_FFFF);
        rchk("resv_0c", 32'hC, 32'd0);
`endif

        // async reset with entries queued
        for (int i = 0; i < 3; i++) wr(32'h0, words[i]);
        rchk("q3_status", 32'h8, 32'h0000_0300);
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'b0, PortOutValid}, 32'd0);
        chk("arst_portout", PortOut, 32'd0);
        rchk("arst_status", 32'h8, 32'h0000_0001);
        rchk("arst_rx", 32'h4, 32'd0);
        rchk("arst_txdata", 32'h0, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_valid", {31'b0, PortOutValid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
